// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer: states,
// ctrlSig bit positions, datapath select codes and trap causes.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    localparam int unsigned CS_ALU    = 0;
    localparam int unsigned CS_IFRM   = 1;
    localparam int unsigned CS_SHIFT  = 2;
    localparam int unsigned CS_LOAD   = 3;
    localparam int unsigned CS_STORE  = 4;
    localparam int unsigned CS_BRANCH = 5;
    localparam int unsigned CS_JALR   = 6;
    localparam int unsigned CS_JAL    = 7;
    localparam int unsigned CS_AUIPC  = 8;
    localparam int unsigned CS_LUI    = 9;
    localparam int unsigned CS_USED   = 10;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    // Only the class bits that steer sequencing or selects are kept.
    typedef struct packed {
        logic ifrm;
        logic load;
        logic store;
        logic branch;
        logic jalr;
        logic jal;
        logic auipc;
        logic lui;
    } cls_t;

    function automatic cls_t decode_class(input logic [CS_USED-1:0] c);
        cls_t r;
        r.ifrm   = c[CS_IFRM];
        r.load   = c[CS_LOAD];
        r.store  = c[CS_STORE];
        r.branch = c[CS_BRANCH];
        r.jalr   = c[CS_JALR];
        r.jal    = c[CS_JAL];
        r.auipc  = c[CS_AUIPC];
        r.lui    = c[CS_LUI];
        return r;
    endfunction

    function automatic logic is_legal(input logic [CS_USED-1:0] c);
        return c[CS_ALU] | c[CS_IFRM] | c[CS_SHIFT] | c[CS_LOAD] | c[CS_STORE] |
               c[CS_BRANCH] | c[CS_JALR] | c[CS_JAL] | c[CS_AUIPC] | c[CS_LUI];
    endfunction

endpackage

// File: rtl/core_ctrl_timeout.sv
// 8-bit wait counter: clears on clr, counts while en, saturates at LIMIT and
// flags expiry once the count has reached LIMIT.
module core_ctrl_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expired = (cnt_q == 8'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the RV32I core.
// Optional CORE_CTRL_PERF_EN adds cyc_cnt/instret performance counters.
module core_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_sig,
    input  logic              br_taken,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              imem_req,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              alu_a_sel,
    output logic              alu_b_sel,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              rf_we,
    output logic [1:0]        wb_sel,
    output logic [2:0]        state,
    output logic              trap,
    output logic [1:0]        trap_cause
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       instret
`endif
);

    state_t     state_q, state_d;
    cls_t       class_q, class_d;
    logic [1:0] cause_q, cause_d;
    logic       run_q;
    logic       to_clr, to_en, to_expired;
    logic       exec_jump;
    logic       unused_ctrl_hi;

    assign unused_ctrl_hi = ^ctrl_sig[CTRL_W-1:CS_USED];

    // run_q holds every output low until the first edge after reset release.
    assign exec_jump = !(class_q.load | class_q.store) && !class_q.branch &&
                       (class_q.jal | class_q.jalr);

    assign to_clr = (state_d != state_q);
    assign to_en  = ((state_q == FETCH) && run_q && !imem_ready) ||
                    ((state_q == MEM) && !dmem_ready);

    core_ctrl_timeout #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (to_clr),
        .en     (to_en),
        .expired(to_expired)
    );

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        cause_d = cause_q;
        case (state_q)
            FETCH: begin
                if (run_q) begin
                    if (imem_ready) begin
                        state_d = DECODE;
                    end else if (to_expired) begin
                        state_d = TRAP;
                        cause_d = CAUSE_IMEM_TO;
                    end
                end
            end
            DECODE: begin
                class_d = decode_class(ctrl_sig[CS_USED-1:0]);
                if (!is_legal(ctrl_sig[CS_USED-1:0])) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (class_q.load || class_q.store) begin
                    state_d = MEM;
                end else if (class_q.branch) begin
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    state_d = class_q.store ? FETCH : WB;
                end else if (to_expired) begin
                    state_d = TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        case (state_q)
            FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
            end
            EXEC: begin
                alu_a_sel = class_q.auipc | class_q.jal | class_q.branch;
                alu_b_sel = class_q.ifrm | class_q.load | class_q.store |
                            class_q.auipc | class_q.jal | class_q.branch;
                if (!(class_q.load || class_q.store)) begin
                    if (class_q.branch) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                    end else if (class_q.jal) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_IMM;
                    end else if (class_q.jalr) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_JALR;
                    end
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = class_q.store;
                pc_we    = class_q.store & dmem_ready;
            end
            WB: begin
                rf_we = 1'b1;
                pc_we = !exec_jump;
                if (class_q.load) begin
                    wb_sel = WB_LOAD;
                end else if (class_q.jal || class_q.jalr) begin
                    wb_sel = WB_PC4;
                end else if (class_q.lui) begin
                    wb_sel = WB_IMM;
                end
            end
            default: ;
        endcase
    end

    assign state      = state_q;
    assign trap       = (state_q == TRAP);
    assign trap_cause = cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            class_q <= '0;
            cause_q <= CAUSE_NONE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cause_q <= cause_d;
            run_q   <= 1'b1;
        end
    end

`ifdef CORE_CTRL_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] ret_q;
    logic        retire;

    assign retire = (state_q == WB) ||
                    ((state_q == EXEC) && class_q.branch && !(class_q.load || class_q.store)) ||
                    ((state_q == MEM) && dmem_ready && class_q.store);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else if (state_q != TRAP) begin
            cyc_q <= cyc_q + 32'd1;
            if (retire) begin
                ret_q <= ret_q + 32'd1;
            end
        end
    end

    assign cyc_cnt = cyc_q;
    assign instret = ret_q;
`endif

endmodule
